// File: rtl/conv_pkg.sv
// Shared sizing and requantizer for the systolic row receive path.
// Used by conv_row_collector and by the feeder/skew block, so both sides
// agree on column count, partial-sum width and output format.
package conv_pkg;

   localparam int unsigned CW       = 16;              // partial-sum width before growth
   localparam int unsigned COLUMN   = 6;               // MAC columns per row
   localparam int unsigned OW       = 8;               // requantized width per column
   localparam int unsigned DEPTH    = 8;               // row FIFO depth, power of 2
   localparam int unsigned IW       = CW + 1;          // per-column input width
   localparam int unsigned XW       = CW + 2;          // rounding headroom, never wraps
   localparam int unsigned SKEW     = COLUMN - 1;      // deskew depth of column 0
   localparam int unsigned LAT      = COLUMN;          // in_valid edge to out_valid edge
   localparam int unsigned CNTW     = $clog2(DEPTH) + 1;
   localparam int unsigned AF_LEVEL = DEPTH - (COLUMN + 1);

   localparam logic signed [XW-1:0] QMAX = XW'((1 << (OW - 1)) - 1);
   localparam logic signed [XW-1:0] QMIN = ~QMAX;      // -QMAX-1

   typedef logic signed [IW-1:0] psum_t;
   typedef logic signed [OW-1:0] qout_t;

   // Round-half-up, arithmetic shift, saturate to OW bits, optional ReLU.
   function automatic qout_t quant_sat(input psum_t x, input logic [4:0] shift,
                                       input logic relu_en);
      logic [4:0]           sh;
      logic signed [XW-1:0] rnd;
      logic signed [XW-1:0] sum;
      logic signed [XW-1:0] y;
      qout_t                q;
      sh  = (shift > 5'(CW)) ? 5'(CW) : shift;
      rnd = (sh == 5'd0) ? '0 : (XW'(1) << (sh - 5'd1));
      sum = {x[IW-1], x} + rnd;
      y   = sum >>> sh;
      if (y > QMAX) begin
         q = QMAX[OW-1:0];
      end else if (y < QMIN) begin
         q = QMIN[OW-1:0];
      end else begin
         q = y[OW-1:0];
      end
      if (relu_en && q[OW-1]) begin
         q = '0;
      end
      return q;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous row FIFO with a registered head row.
// Ports: push/wdata write a row (ignored when full unless a pop happens on
// the same edge); pop removes the head when valid; rdata is the head row
// held in a register; valid/empty/full/almost_full/count are all registered.
module sync_fifo #(
   parameter int unsigned W        = 48,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     valid,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;

   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [W-1:0]    head_q, head_d;
   logic            valid_q, valid_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            af_q, af_d;
   logic            pop_ok_c;
   logic            push_ok_c;

   // Pointer/count update and next head row.
   always_comb begin
      pop_ok_c  = pop & valid_q;
      push_ok_c = push & (~full_q | pop_ok_c);
      rptr_d    = rptr_q + AW'(pop_ok_c);
      wptr_d    = wptr_q + AW'(push_ok_c);
      count_d   = count_q + CNTW'(push_ok_c) - CNTW'(pop_ok_c);
      head_d    = head_q;
      // Written row becomes head when no older row survives this edge.
      if (push_ok_c && (count_q == CNTW'(pop_ok_c))) begin
         head_d = wdata;
      end else if (count_d != '0) begin
         head_d = mem_q[rptr_d];
      end
      valid_d = (count_d != '0);
      empty_d = (count_d == '0);
      full_d  = (count_d == CNTW'(DEPTH));
      af_d    = (count_d >= CNTW'(AF_LEVEL));
   end

   // Row storage, not reset: contents are qualified by count.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= valid_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         af_q    <= af_d;
      end
   end

   assign rdata       = head_q;
   assign valid       = valid_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign count       = count_q;

endmodule

// File: rtl/conv_row_collector.sv
// Receive end of a systolic MAC row: deskews the time-staggered column
// partial sums into one row, requantizes each column, and queues rows in a
// FIFO drained by a valid/ready handshake.
// Ports: in_valid/psum_in carry column 0 valid now, column i i cycles later;
// shift/relu_en configure requantization; out_valid/out_ready/out_data is
// the row stream; almost_full throttles upstream; overflow is a sticky drop
// flag cleared by clear_ovf; count is FIFO occupancy.
module conv_row_collector
   import conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [COLUMN*IW-1:0]   psum_in,
   input  logic [4:0]             shift,
   input  logic                   relu_en,
   input  logic                   clear_ovf,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COLUMN*OW-1:0]   out_data,
   output logic                   almost_full,
   output logic                   overflow,
   output logic [CNTW-1:0]        count
);

   psum_t               aligned_c [COLUMN];
   logic [SKEW-1:0]     vpipe_q, vpipe_d;
   logic [COLUMN*OW-1:0] qdata_q, qdata_d;
   logic                qvalid_q, qvalid_d;
   logic                overflow_q, overflow_d;
   logic                drop_c;
   logic                fifo_full;
   logic                fifo_empty;

   // Column i is delayed SKEW-i cycles so every column lands with column SKEW.
   for (genvar i = 0; i < COLUMN; i++) begin : g_col
      localparam int unsigned D = SKEW - i;
      if (D == 0) begin : g_direct
         assign aligned_c[i] = psum_in[i*IW +: IW];
      end else begin : g_dly
         logic [IW-1:0] dly_q [D];
         logic [IW-1:0] dly_d [D];
         always_comb begin
            dly_d[0] = psum_in[i*IW +: IW];
            for (int k = 1; k < D; k++) begin
               dly_d[k] = dly_q[k-1];
            end
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < D; k++) begin
                  dly_q[k] <= '0;
               end
            end else begin
               dly_q <= dly_d;
            end
         end
         assign aligned_c[i] = dly_q[D-1];
      end
   end

   // Valid pipe, requantizer stage and sticky overflow.
   always_comb begin
      vpipe_d  = (vpipe_q << 1) | SKEW'(in_valid);
      qvalid_d = vpipe_q[SKEW-1];
      qdata_d  = '0;
      for (int i = 0; i < COLUMN; i++) begin
         qdata_d[i*OW +: OW] = quant_sat(aligned_c[i], shift, relu_en);
      end
      // A row is lost only when full and nothing leaves on the same edge.
      drop_c     = qvalid_q & fifo_full & ~(out_ready & ~fifo_empty);
      overflow_d = drop_c | (overflow_q & ~clear_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe_q    <= '0;
         qdata_q    <= '0;
         qvalid_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         vpipe_q    <= vpipe_d;
         qdata_q    <= qdata_d;
         qvalid_q   <= qvalid_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .W        (COLUMN*OW),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (qvalid_q),
      .wdata       (qdata_q),
      .pop         (out_ready),
      .rdata       (out_data),
      .valid       (out_valid),
      .empty       (fifo_empty),
      .full        (fifo_full),
      .almost_full (almost_full),
      .count       (count)
   );

   assign overflow = overflow_q;

endmodule

// File: doc/conv_row_collector.md
Name: conv_row_collector

Overview:
- Receive end of a systolic MAC row.
- Takes the time-skewed column partial sums (column i is valid i cycles after column 0) and realigns them into one row vector.
- Requantizes each column to OW bits (round, shift, saturate, optional ReLU).
- Buffers rows in a FIFO drained through a valid/ready handshake, so the row output can be written to the feature-map store or passed to the next layer.

Parameters:
- CW, 16, partial-sum width per column before growth; inputs are CW+1 bits, signed two's complement.
- COLUMN, 6, number of MAC columns in the row.
- OW, 8, output width per column, signed.
- DEPTH, 8, FIFO depth in rows, power of 2, >= COLUMN+2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  column-0 result on psum_in is valid this cycle.
- psum_in  in  COLUMN*(CW+1)  column i at bits [i*(CW+1) +: CW+1]; column i valid i cycles after column 0.
- shift  in  5  right-shift amount, 0..CW; quasi-static.
- relu_en  in  1  clamp negatives to 0; quasi-static.
- clear_ovf  in  1  clears the overflow flag.
- out_valid  out  1  FIFO head row available.
- out_ready  in  1  consumer accepts the head row.
- out_data  out  COLUMN*OW  head row; column i at bits [i*OW +: OW].
- almost_full  out  1  upstream must stop launching rows.
- overflow  out  1  sticky: a row was dropped.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): all deskew registers, valid pipe, quantizer register, FIFO pointers and count clear to 0. out_valid=0, out_data=0, almost_full=0, overflow=0. A row in flight when reset asserts is discarded.
- Deskew:
  - Column i passes through COLUMN-1-i registers; column COLUMN-1 is unregistered.
  - in_valid passes through a COLUMN-1 deep valid pipe.
  - After deskew, all columns of a row sit in the same cycle.
  - Data registers are free-running; only the valid bit qualifies them.
- Quantize stage: one register, loaded every cycle. Per column, with x = signed CW+1 input:
  - shift=0: y = x.
  - shift>0: y = (x + 2^(shift-1)) >>> shift. The addition is done at CW+2 bits, so no wrap.
  - shift > CW is treated as CW.
  - Saturate y to [-2^(OW-1), 2^(OW-1)-1].
  - If relu_en=1 and y<0, y=0.
- FIFO write: the quantize-stage valid writes the row. Latency: in_valid sampled at edge k, with the FIFO empty, gives out_valid=1 after edge k+COLUMN and out_data equal to that row.
- FIFO read:
  - A row pops on an edge with out_valid & out_ready.
  - out_data always shows the head row and holds stable while out_valid=1 and out_ready=0.
  - No combinational path from out_ready to out_valid.
- Full with a write pending:
  - If a pop occurs on the same edge, the write is accepted and count is unchanged.
  - Otherwise the row is dropped and overflow is set.
- Empty with out_ready=1: no pop, count stays 0.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
- Pointers wrap modulo DEPTH.
- almost_full = (count >= DEPTH-(COLUMN+1)). This is registered from the next-count value and covers rows still in the pipeline.
- overflow: set on a drop, cleared by clear_ovf. If a drop and clear_ovf occur on the same edge, set wins.
- Back-to-back in_valid every cycle is supported at full throughput.

Decomposition:
- Package conv_pkg:
  - function quant_sat(x, shift, relu_en) carrying CW/OW.
  - localparams SKEW = COLUMN-1 and LAT = COLUMN.
  - Shared with the feeder/skew block.
- Sub-module sync_fifo (parameters W = COLUMN*OW and DEPTH):
  - push, pop, full, empty, count.
  - Registered data output via a head register.
- Deskew lines and quantizer stay in conv_row_collector as generate loops.

Test Plan:
- Latency/alignment: COLUMN=6, shift=0, relu_en=0. in_valid at edge 10 with column i = i+1, each column presented at its skewed cycle, out_ready=1. Required: out_valid high after edge 16 for exactly 1 cycle; out_data columns = {1,2,3,4,5,6}.
- Quantize: shift=4, inputs 24, -24, 4000, -4000, 7, 8.
  - relu_en=0 requires 2, -1, 127, -128, 0, 1.
  - relu_en=1 requires 2, 0, 127, 0, 0, 1.
- Backpressure: out_ready=0, 8 rows streamed back-to-back. Required:
  - count reaches 8.
  - almost_full asserts once count >= 1.
  - overflow stays 0.
  - out_data holds row 0.
- Overflow: continue with a 9th row while out_ready=0. Required:
  - Row dropped, overflow=1.
  - Draining yields rows 0..7 in order.
  - clear_ovf pulse gives overflow=0.
- Full simultaneous push/pop: FIFO full, out_ready=1 on the same edge a new row writes. Required: count stays 8, no overflow, new row emerges last.
- Reset mid-stream: assert rst_n=0 with 3 rows in the pipe and 4 in the FIFO. Required: immediately out_valid=0, count=0, overflow=0; after release, no stale row ever appears.
